ball_circle_draw: RTL and testbench
===================================

// Module: ball_circle_draw
// PURPOSE
//  Parametrised ball renderer for the pong VGA path (160x120 framebuffer, 8b x / 7b y).
//  Watches the requested ball centre. On a change it erases the old circle in background colour,
//  then draws the new circle in ball colour, using the midpoint circle algorithm.
//  One pixel per clock goes to the VGA adapter. Off-screen pixels are suppressed.
//  Sits between the ball-physics block and the VGA adapter.
// PARAMETERS
//  RADIUS      4       circle radius in pixels, 1..15
//  SCREEN_W    160     visible width; pixels with x >= SCREEN_W are clipped
//  SCREEN_H    120     visible height; pixels with y >= SCREEN_H are clipped
//  COLOUR_W    3       colour bus width
//  BALL_COLOUR 3'b111  colour used on draw passes
//  BG_COLOUR   3'b000  colour used on erase passes
//  ERASE_EN    1       1: erase the old circle before drawing; 0: draw-only mode
// PORTS
//  clock       in   1         system clock, all state on posedge
//  reset       in   1         synchronous, active-high
//  x           in   8         requested ball centre x
//  y           in   7         requested ball centre y
//  vga_x       out  8         pixel x to VGA adapter
//  vga_y       out  7         pixel y to VGA adapter
//  vga_colour  out  COLOUR_W  pixel colour
//  vga_plot    out  1         write strobe; vga_x/y/colour are valid only while high
//  busy        out  1         high while an erase or draw pass is in progress
//  done        out  1         one-cycle pulse when the last pass of an update ends
// BEHAVIOUR
//  Reset values
//  - All outputs 0. State IDLE. Stored centre c_x/c_y = 0. first flag = 1 (no circle on screen).
//  FSM states: IDLE -> ERASE -> DRAW -> IDLE.
//  - IDLE: if first==1 or {x,y} != {c_x,c_y}, latch the new centre n_x/n_y and set busy.
//    Next state is ERASE if ERASE_EN and !first; otherwise DRAW.
//  - x/y are ignored outside IDLE. A change while busy is picked up on the next IDLE cycle.
//  - ERASE pass: centre c_x/c_y, BG_COLOUR.
//  - DRAW pass: centre n_x/n_y, BALL_COLOUR.
//  - End of DRAW: c <= n, first <= 0, done pulses, busy drops, state returns to IDLE.
//  Pass algorithm
//  - Init: ox = RADIUS, oy = 0, crit = 1 - RADIUS.
//  - Each iteration spends 8 cycles, one per octant, in order:
//    (+ox,+oy) (+oy,+ox) (-ox,+oy) (-oy,+ox) (-ox,-oy) (-oy,-ox) (+ox,-oy) (+oy,-ox),
//    each added to the centre.
//  - After octant 8: oy <= oy+1.
//    If crit <= 0: crit += 2*oy_new + 1.
//    Else: ox <= ox-1, crit += 2*(oy_new - ox_new) + 1.
//  - Iterate while oy <= ox (test done on the updated values). RADIUS=4 gives 4 iterations, 32 cycles.
//  - Duplicate pixels on the diagonal or axes are plotted again; they are not filtered.
//  - Pass cycle count = 8*N, fixed regardless of clipping. ERASE goes straight into DRAW, no gap.
//  Arithmetic and clipping
//  - Coordinates are computed signed, 10 bits wide. crit is signed, 7 bits wide.
//  - Pixel plotted only if 0 <= px < SCREEN_W and 0 <= py < SCREEN_H.
//    Otherwise vga_plot = 0 for that cycle and the coordinate is never wrapped.
//  Output timing
//  - Outputs are registered. The pixel for an octant cycle appears on vga_* one clock later.
//  - done is asserted in the same cycle as the last pixel's vga_plot.
//  - vga_plot is 0 in IDLE.
//  Reset mid-pass
//  - Abort immediately. Next cycle all outputs are 0 and first = 1.
//  - The next update draws without an erase (a partial ghost may remain; this is accepted).
// TESTING
//  1. Reset 2 cycles -> vga_plot, busy, done all 0.
//     Release with x=80, y=60 -> DRAW only; 32 plot cycles.
//     First pixel (84,60) colour 3'b111; done on cycle 32.
//  2. Hold x=80, y=60 after test 1 for 100 cycles -> busy stays 0, no plots.
//  3. Move to x=81 -> 32 ERASE pixels around (80,60) in 3'b000, first (84,60).
//     Then 32 DRAW pixels around (81,60), first (85,60). Single done after 64 cycles.
//  4. Centre (1,1) -> still 64 cycles total (erase + draw).
//     vga_plot low on every cycle with px<0 or py<0; no vga_x of 255 or vga_y of 127 ever seen.
//  5. Change x to 90 at draw cycle 10, then to 95 at cycle 20 ->
//     current pass finishes unchanged, next update targets (95,60).
//  6. Assert reset at draw cycle 15 -> next cycle outputs 0.
//     Next centre is drawn with no erase pass (32 cycles).

Source files
------------

// File: rtl/ball_circle_draw.sv
// Ball renderer: erases the old ball and draws the new one with the midpoint
// circle algorithm. One pixel per clock goes to the VGA adapter; off-screen pixels are clipped.
module ball_circle_draw #(
  parameter int                   RADIUS      = 4,
  parameter int                   SCREEN_W    = 160,
  parameter int                   SCREEN_H    = 120,
  parameter int                   COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0]  BALL_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR   = 3'b000,
  parameter bit                   ERASE_EN    = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW} state_t;

  localparam logic signed [9:0] SW        = 10'(SCREEN_W);
  localparam logic signed [9:0] SH        = 10'(SCREEN_H);
  localparam logic signed [9:0] OX_INIT   = 10'(RADIUS);
  localparam logic signed [6:0] CRIT_INIT = 7'(1 - RADIUS);

  state_t               state_q, state_d;
  logic [7:0]           c_x_q, c_x_d, n_x_q, n_x_d;
  logic [6:0]           c_y_q, c_y_d, n_y_q, n_y_d;
  logic                 first_q, first_d;
  logic signed [9:0]    ox_q, ox_d, oy_q, oy_d;
  logic signed [6:0]    crit_q, crit_d;
  logic [2:0]           oct_q, oct_d;
  logic [7:0]           vga_x_q, vga_x_d;
  logic [6:0]           vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]  vga_colour_q, vga_colour_d;
  logic                 vga_plot_q, vga_plot_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic signed [9:0]    cen_x, cen_y, dx, dy, px, py;
  logic signed [9:0]    oy_n, ox_n, crit_w, crit_sum;
  logic                 in_scr, pass_end;

  always_comb begin
    // Erase uses the stored centre, draw uses the newly latched one
    cen_x = (state_q == S_ERASE) ? {2'b00, c_x_q} : {2'b00, n_x_q};
    cen_y = (state_q == S_ERASE) ? {3'b000, c_y_q} : {3'b000, n_y_q};
    dx = ox_q;
    dy = oy_q;
    case (oct_q)
      3'd0: begin dx =  ox_q; dy =  oy_q; end
      3'd1: begin dx =  oy_q; dy =  ox_q; end
      3'd2: begin dx = -ox_q; dy =  oy_q; end
      3'd3: begin dx = -oy_q; dy =  ox_q; end
      3'd4: begin dx = -ox_q; dy = -oy_q; end
      3'd5: begin dx = -oy_q; dy = -ox_q; end
      3'd6: begin dx =  ox_q; dy = -oy_q; end
      default: begin dx = oy_q; dy = -ox_q; end
    endcase
    px = cen_x + dx;
    py = cen_y + dy;
    in_scr = !px[9] && (px < SW) && !py[9] && (py < SH);

    oy_n   = oy_q + 10'sd1;
    crit_w = {{3{crit_q[6]}}, crit_q};
    if (crit_q <= 7'sd0) begin
      ox_n     = ox_q;
      crit_sum = crit_w + (oy_n <<< 1) + 10'sd1;
    end else begin
      ox_n     = ox_q - 10'sd1;
      crit_sum = crit_w + ((oy_n - ox_n) <<< 1) + 10'sd1;
    end
    pass_end = (oct_q == 3'd7) && (oy_n > ox_n);
  end

  always_comb begin
    state_d      = state_q;
    c_x_d        = c_x_q;
    c_y_d        = c_y_q;
    n_x_d        = n_x_q;
    n_y_d        = n_y_q;
    first_d      = first_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    crit_d       = crit_q;
    oct_d        = oct_q;
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    vga_plot_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (first_q || ({x, y} != {c_x_q, c_y_q})) begin
          n_x_d   = x;
          n_y_d   = y;
          busy_d  = 1'b1;
          state_d = (ERASE_EN && !first_q) ? S_ERASE : S_DRAW;
          ox_d    = OX_INIT;
          oy_d    = '0;
          crit_d  = CRIT_INIT;
          oct_d   = '0;
        end
      end
      S_ERASE, S_DRAW: begin
        // Clipped cycles still consume their slot so pass length is fixed
        if (in_scr) begin
          vga_plot_d   = 1'b1;
          vga_x_d      = px[7:0];
          vga_y_d      = py[6:0];
          vga_colour_d = (state_q == S_ERASE) ? BG_COLOUR : BALL_COLOUR;
        end
        oct_d = oct_q + 3'd1;
        if (oct_q == 3'd7) begin
          ox_d   = ox_n;
          oy_d   = oy_n;
          crit_d = crit_sum[6:0];
        end
        if (pass_end) begin
          if (state_q == S_ERASE) begin
            state_d = S_DRAW;
            ox_d    = OX_INIT;
            oy_d    = '0;
            crit_d  = CRIT_INIT;
            oct_d   = '0;
          end else begin
            state_d = S_IDLE;
            c_x_d   = n_x_q;
            c_y_d   = n_y_q;
            first_d = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      c_x_q        <= '0;
      c_y_q        <= '0;
      n_x_q        <= '0;
      n_y_q        <= '0;
      first_q      <= 1'b1;
      ox_q         <= '0;
      oy_q         <= '0;
      crit_q       <= '0;
      oct_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_x_q        <= c_x_d;
      c_y_q        <= c_y_d;
      n_x_q        <= n_x_d;
      n_y_q        <= n_y_d;
      first_q      <= first_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      crit_q       <= crit_d;
      oct_q        <= oct_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ball_circle_draw.sv
// Scoreboard bench for ball_circle_draw: a bench-side circle model queues the
// per-cycle pixel stream of each update, and a negedge monitor pops and compares it.
module tb_ball_circle_draw;

  localparam int R = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x = 8'd80;
  logic [6:0] y = 7'd60;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  ball_circle_draw dut (
    .clock(clock), .reset(reset), .x(x), .y(y),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       plot;
    int       px;
    int       py;
    int       col;
    bit       done;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   m_cx = 0, m_cy = 0;
  bit   m_first = 1'b1;
  bit   busy_prev = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_pass(input int cx, input int cy, input int col, input bit last);
    int ox, oy, crit, dx, dy;
    exp_t e;
    ox = R; oy = 0; crit = 1 - R;
    do begin
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin dx =  ox; dy =  oy; end
          1: begin dx =  oy; dy =  ox; end
          2: begin dx = -ox; dy =  oy; end
          3: begin dx = -oy; dy =  ox; end
          4: begin dx = -ox; dy = -oy; end
          5: begin dx = -oy; dy = -ox; end
          6: begin dx =  ox; dy = -oy; end
          default: begin dx = oy; dy = -ox; end
        endcase
        e.px = cx + dx;
        e.py = cy + dy;
        e.plot = (e.px >= 0) && (e.px < 160) && (e.py >= 0) && (e.py < 120);
        e.col = col;
        e.done = 1'b0;
        sb.push_back(e);
      end
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
    if (last) begin
      e = sb.pop_back();
      e.done = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic do_update(input int nx, input int ny);
    x = nx[7:0];
    y = ny[6:0];
    if (!m_first) push_pass(m_cx, m_cy, 0, 1'b0);
    push_pass(nx, ny, 7, 1'b1);
    m_cx = nx; m_cy = ny; m_first = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 1000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_timeout", int'(n >= 1000), 0);
    @(posedge clock); #1;
  endtask

  // The pixel of a pass cycle is visible one clock after busy was seen high
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev) begin
        if (sb.size() == 0) chk("extra_pass_cycle", 1, 0);
        else begin
          e = sb.pop_front();
          chk("plot", int'(vga_plot), int'(e.plot));
          chk("done", int'(done), int'(e.done));
          if (e.plot) begin
            chk("vga_x", int'(vga_x), e.px);
            chk("vga_y", int'(vga_y), e.py);
            chk("colour", int'(vga_colour), e.col);
          end
        end
      end else begin
        chk("idle_plot", int'(vga_plot), 0);
        chk("idle_done", int'(done), 0);
      end
      busy_prev = busy;
    end
  end

  initial begin
    // 1: reset then first draw, no erase
    repeat (2) @(posedge clock);
    #1;
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    do_update(80, 60);
    wait_idle();

    // 2: unchanged centre stays quiet
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      chk("hold_busy", int'(busy), 0);
    end

    // 3: move by one pixel
    do_update(81, 60);
    wait_idle();

    // 4: near the corner, heavy clipping
    do_update(1, 1);
    wait_idle();

    // 5: input changes while busy are deferred to the next idle cycle
    do_update(80, 60);
    repeat (43) @(posedge clock);
    #1;
    x = 8'd90;
    repeat (10) @(posedge clock);
    #1;
    do_update(95, 60);
    wait_idle();

    // 6: reset in the middle of the draw pass
    do_update(40, 60);
    repeat (48) @(posedge clock);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    reset = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    chk("mid_rst_plot", int'(vga_plot), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_x", int'(vga_x), 0);
    reset = 1'b0;
    m_first = 1'b1;
    do_update(40, 60);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
